// File: rtl/elastic_register_pkg.sv
// Shared constants and helpers for the elastic register: BURST mode strings
// and the constant log2 functions used to size pointers and the occupancy count.
package elastic_register_pkg;

  localparam string BURST_YES = "yes";
  localparam string BURST_NO  = "no";

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  function automatic int ptr_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

endpackage

// File: rtl/elastic_register_ptr.sv
// Modulo-DEPTH wrap-around pointer with advance enable and synchronous clear.
// DEPTH need not be a power of two.
module elastic_register_ptr
  import elastic_register_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = ptr_width(DEPTH)
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (en_i) begin
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/elastic_register.sv
// DEPTH-entry valid/ready elastic buffer; outputs come straight from flops.
// Optional synchronous flush port enabled by defining ELASTIC_REGISTER_FLUSH_EN.
module elastic_register
  import elastic_register_pkg::*;
#(
  parameter int    WIDTH = 8,
  parameter int    DEPTH = 2,
  parameter string BURST = "yes"
) (
  input  logic             iCLK,
  input  logic             iRST,
`ifdef ELASTIC_REGISTER_FLUSH_EN
  input  logic             iFlush,
`endif
  input  logic             iValid_AM,
  output logic             oReady_AM,
  input  logic [WIDTH-1:0] iData_AM,
  output logic             oValid_BM,
  input  logic             iReady_BM,
  output logic [WIDTH-1:0] oData_BM
);

  localparam int PTR_W    = ptr_width(DEPTH);
  localparam int CNT_W    = clog2(DEPTH + 1);
  localparam bit BURST_EN = (BURST == BURST_YES);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic             flush;
  logic             full;
  logic             push;
  logic             pop;

`ifdef ELASTIC_REGISTER_FLUSH_EN
  assign flush = iFlush;
`else
  assign flush = 1'b0;
`endif

  assign full = (count_q == CNT_W'(DEPTH));

  // Gating with iRST keeps oReady_AM low for the whole time reset is held.
  assign oReady_AM = iRST & ~flush & (~full | (BURST_EN & iReady_BM));
  assign oValid_BM = ~flush & (count_q != '0);
  assign oData_BM  = mem_q[head_q];

  assign push = iValid_AM & oReady_AM;
  assign pop  = oValid_BM & iReady_BM;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  elastic_register_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_head (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .clr_i (flush),
    .en_i  (pop),
    .ptr_o (head_q)
  );

  elastic_register_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_tail (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .clr_i (flush),
    .en_i  (push),
    .ptr_o (tail_q)
  );

  // When full in burst mode the tail slot is the head slot: the old value is
  // read out and the new one written on the same edge.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
        mem_q[gi] <= '0;
      end else if (push && (tail_q == PTR_W'(gi))) begin
        mem_q[gi] <= iData_AM;
      end
    end
  end

endmodule

// File: tb/tb_elastic_register.sv
// Three elastic_register instances (D2/no, D2/yes, D3/yes) checked against a
// list-based occupancy model every cycle plus directed literal checks.
module tb_elastic_register;

  logic       clk;
  logic       rst_n;
  logic [2:0] va;
  logic [2:0] rb;
  logic [2:0] fl;
  logic [2:0] vbm;
  logic [2:0] rdy;
  logic [3:0] din  [3];
  logic [3:0] dout [3];

  int n_cmp;
  int n_bad;

  logic [3:0] mbuf [3][4];
  int         mcnt [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  elastic_register #(.WIDTH(4), .DEPTH(2), .BURST("no")) u_d2_no (
    .iCLK(clk), .iRST(rst_n),
`ifdef ELASTIC_REGISTER_FLUSH_EN
    .iFlush(fl[0]),
`endif
    .iValid_AM(va[0]), .oReady_AM(rdy[0]), .iData_AM(din[0]),
    .oValid_BM(vbm[0]), .iReady_BM(rb[0]), .oData_BM(dout[0])
  );

  elastic_register #(.WIDTH(4), .DEPTH(2), .BURST("yes")) u_d2_yes (
    .iCLK(clk), .iRST(rst_n),
`ifdef ELASTIC_REGISTER_FLUSH_EN
    .iFlush(fl[1]),
`endif
    .iValid_AM(va[1]), .oReady_AM(rdy[1]), .iData_AM(din[1]),
    .oValid_BM(vbm[1]), .iReady_BM(rb[1]), .oData_BM(dout[1])
  );

  elastic_register #(.WIDTH(4), .DEPTH(3), .BURST("yes")) u_d3_yes (
    .iCLK(clk), .iRST(rst_n),
`ifdef ELASTIC_REGISTER_FLUSH_EN
    .iFlush(fl[2]),
`endif
    .iValid_AM(va[2]), .oReady_AM(rdy[2]), .iData_AM(din[2]),
    .oValid_BM(vbm[2]), .iReady_BM(rb[2]), .oData_BM(dout[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dep(input int k);
    return (k == 2) ? 3 : 2;
  endfunction

  // Model: an ordered list per instance; compare now, then apply the transfer
  // that the coming rising edge performs with the inputs currently driven.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        chk($sformatf("m%0d_rst_valid", k), {31'd0, vbm[k]}, 32'd0);
        chk($sformatf("m%0d_rst_ready", k), {31'd0, rdy[k]}, 32'd0);
        chk($sformatf("m%0d_rst_data", k), {28'd0, dout[k]}, 32'd0);
        mcnt[k] = 0;
      end else if (fl[k]) begin
        chk($sformatf("m%0d_fl_valid", k), {31'd0, vbm[k]}, 32'd0);
        chk($sformatf("m%0d_fl_ready", k), {31'd0, rdy[k]}, 32'd0);
        mcnt[k] = 0;
      end else begin
        logic ev;
        logic er;
        ev = (mcnt[k] > 0);
        er = (mcnt[k] < dep(k)) || ((k != 0) && rb[k]);
        chk($sformatf("m%0d_valid", k), {31'd0, vbm[k]}, {31'd0, ev});
        chk($sformatf("m%0d_ready", k), {31'd0, rdy[k]}, {31'd0, er});
        if (ev) chk($sformatf("m%0d_data", k), {28'd0, dout[k]}, {28'd0, mbuf[k][0]});
        if (ev && rb[k]) begin
          for (int i = 0; i < 3; i++) mbuf[k][i] = mbuf[k][i+1];
          mcnt[k] = mcnt[k] - 1;
        end
        if (va[k] && er) begin
          mbuf[k][mcnt[k]] = din[k];
          mcnt[k] = mcnt[k] + 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int k = 0; k < 3; k++) begin
      mcnt[k] = 0;
      din[k]  = 4'h0;
    end
    rst_n = 1'b0;
    va = '0; rb = '0; fl = '0;
    step();
    chk("rst_ready0", {31'd0, rdy[0]}, 32'd0);
    chk("rst_valid0", {31'd0, vbm[0]}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready0", {31'd0, rdy[0]}, 32'd1);

    // Single push then pop, BURST=no.
    va[0] = 1'b1; din[0] = 4'hA;
    step();
    va[0] = 1'b0;
    chk("t1_valid", {31'd0, vbm[0]}, 32'd1);
    chk("t1_data", {28'd0, dout[0]}, 32'hA);
    chk("t1_ready", {31'd0, rdy[0]}, 32'd1);
    rb[0] = 1'b1;
    step();
    chk("t1_empty", {31'd0, vbm[0]}, 32'd0);
    rb[0] = 1'b0;

    // Fill, offer while full, drain.
    va[0] = 1'b1; din[0] = 4'h7;
    step();
    din[0] = 4'h8;
    step();
    din[0] = 4'h9;
    #1;
    chk("t2_full_ready", {31'd0, rdy[0]}, 32'd0);
    step();
    step();
    va[0] = 1'b0;
    chk("t2_head", {28'd0, dout[0]}, 32'h7);
    rb[0] = 1'b1;
    step();
    chk("t2_second", {28'd0, dout[0]}, 32'h8);
    step();
    chk("t2_drained", {31'd0, vbm[0]}, 32'd0);
    rb[0] = 1'b0;

    // Burst: full, simultaneous push and pop.
    va[1] = 1'b1; din[1] = 4'h1;
    step();
    din[1] = 4'h2;
    step();
    din[1] = 4'hC; rb[1] = 1'b1;
    #1;
    chk("t3_burst_ready", {31'd0, rdy[1]}, 32'd1);
    chk("t3_first", {28'd0, dout[1]}, 32'h1);
    step();
    va[1] = 1'b0; rb[1] = 1'b0;
    #1;
    chk("t3_still_full", {31'd0, rdy[1]}, 32'd0);
    chk("t3_second", {28'd0, dout[1]}, 32'h2);
    rb[1] = 1'b1;
    step();
    chk("t3_third", {28'd0, dout[1]}, 32'hC);
    step();
    chk("t3_empty", {31'd0, vbm[1]}, 32'd0);
    rb[1] = 1'b0;

    // Back-to-back streaming through DEPTH=3 with pointer wrap.
    rb[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [3:0] v;
      v = 4'hC + 4'(i);
      va[2] = 1'b1; din[2] = v;
      step();
      chk($sformatf("t4_valid%0d", i), {31'd0, vbm[2]}, 32'd1);
      chk($sformatf("t4_data%0d", i), {28'd0, dout[2]}, {28'd0, v});
    end
    va[2] = 1'b0;
    step();
    chk("t4_empty", {31'd0, vbm[2]}, 32'd0);
    rb[2] = 1'b0;

    // Asynchronous reset mid-operation.
    va[0] = 1'b1; din[0] = 4'h3;
    step();
    din[0] = 4'h4;
    step();
    va[0] = 1'b0;
    chk("t5_loaded", {31'd0, vbm[0]}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {31'd0, vbm[0]}, 32'd0);
    chk("t5_rst_data", {28'd0, dout[0]}, 32'h0);
    chk("t5_rst_ready", {31'd0, rdy[0]}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("t5_rel_ready", {31'd0, rdy[0]}, 32'd1);
    chk("t5_rel_valid", {31'd0, vbm[0]}, 32'd0);

`ifdef ELASTIC_REGISTER_FLUSH_EN
    va[0] = 1'b1; din[0] = 4'h5;
    step();
    din[0] = 4'h6;
    step();
    din[0] = 4'hB; fl[0] = 1'b1;
    #1;
    chk("t6_fl_ready", {31'd0, rdy[0]}, 32'd0);
    chk("t6_fl_valid", {31'd0, vbm[0]}, 32'd0);
    step();
    fl[0] = 1'b0; va[0] = 1'b0;
    #1;
    chk("t6_after_valid", {31'd0, vbm[0]}, 32'd0);
    va[0] = 1'b1;
    step();
    va[0] = 1'b0;
    chk("t6_push_data", {28'd0, dout[0]}, 32'hB);
    rb[0] = 1'b1;
    step();
    chk("t6_alone", {31'd0, vbm[0]}, 32'd0);
    rb[0] = 1'b0;
`endif

    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/elastic_register.md
Name: elastic_register

Overview:
- Parametrised successor to the single-slot valid/ready Register: a DEPTH-entry elastic pipeline buffer with WIDTH-bit payload and selectable BURST mode.
- Sits between any two valid/ready stages (AM = upstream, BM = downstream) in the datapath.
- Decouples backpressure and gives full throughput with no combinational data path from iData_AM to oData_BM.

Parameters:
- WIDTH, 8, payload width in bits (>=1).
- DEPTH, 2, number of storage slots (>=1, need not be a power of 2).
- BURST, "yes", "yes": oReady_AM also asserts when full and downstream pops in the same cycle (combinational iReady_BM->oReady_AM path); "no": oReady_AM depends only on registered state.

Ports:
- iCLK  in  1  clock; all state updates on rising edge.
- iRST  in  1  asynchronous reset, active-low.
- iValid_AM  in  1  upstream data valid.
- oReady_AM  out  1  block can accept upstream data.
- iData_AM  in  WIDTH  upstream payload.
- oValid_BM  out  1  downstream data valid.
- iReady_BM  in  1  downstream can accept.
- oData_BM  out  WIDTH  downstream payload (head slot).

Behaviour:
- push = iValid_AM & oReady_AM; pop = oValid_BM & iReady_BM.
- State:
  - mem[0..DEPTH-1];
  - head/tail pointers, width max(1, clog2(DEPTH));
  - count, width clog2(DEPTH+1).
- Reset (iRST low, asynchronous):
  - count=0, head=tail=0, all mem slots=0.
  - oValid_BM=0, oData_BM=0, oReady_AM=0 while iRST is low.
  - After release, oReady_AM=1 in the first cycle.
- oValid_BM = (count!=0); oData_BM = mem[head]. Driven only from flops.
- Latency: data pushed at edge N is visible on oData_BM after edge N (earliest pop at edge N+1). No same-cycle fall-through.
- oReady_AM:
  - BURST="no": (count<DEPTH).
  - BURST="yes": (count<DEPTH) | iReady_BM.
- Push: mem[tail]<=iData_AM; tail wraps DEPTH-1 -> 0.
- Pop: head advances, wrapping DEPTH-1 -> 0.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
  - neither: hold.
- Full + simultaneous push/pop (BURST="yes" only): tail==head slot is read out and rewritten in the same edge. Order is preserved.
- Empty + iReady_BM=1 + push: no pop that cycle (oValid_BM=0). Data appears next cycle.
- Stability: while oValid_BM & ~iReady_BM, oData_BM and oValid_BM hold. The upstream must hold iData_AM while iValid_AM & ~oReady_AM. The block does not check this.
- iValid_AM asserted when not ready: ignored, no state change.
- Throughput: 1 transfer/cycle sustained for DEPTH>=2 in both modes. For DEPTH=1: 1/cycle only with BURST="yes"; 1 per 2 cycles with BURST="no".

Optional Feature:
- Macro: ELASTIC_REGISTER_FLUSH_EN.
- Defined:
  - Adds port iFlush (in, 1). iFlush=1 at an edge sets count=0, head=tail=0; mem is not cleared.
  - Flush has priority over push and pop.
  - oReady_AM=0 and oValid_BM=0 combinationally during the iFlush cycle, so no handshake completes.
- Undefined: port absent, no flush logic.

Decomposition:
- Shared header (`include, alongside the existing test/utility headers) holds:
  - clog2 constant function;
  - BURST mode string constants "yes"/"no".
- One natural sub-module: elastic_register_ptr, a wrap-around modulo-DEPTH pointer counter with enable. Instantiated twice (head, tail).

Test Plan:
- WIDTH=4, DEPTH=2, BURST="no". Push 0xA with iReady_BM=0.
  - Next cycle: oValid_BM=1, oData_BM=0xA, oReady_AM=1.
  - Raise iReady_BM: 0xA popped, oValid_BM=0 the following cycle.
- Same config. Push 0x7, 0x8 with iReady_BM=0.
  - count=2, oReady_AM=0; offered 0x9 is ignored.
  - Drain: outputs 0x7 then 0x8, then oValid_BM=0.
- BURST="yes", DEPTH=2, full with 0x1, 0x2. Assert iReady_BM=1 and present 0xC.
  - oReady_AM=1 that cycle; count stays 2.
  - Outputs 0x1, 0x2, 0xC in order.
- DEPTH=3, iReady_BM=1, back-to-back pushes 0xC, 0xD, 0xE, 0xF, 0x0.
  - Each appears on oData_BM one cycle after its push, with no bubbles.
  - Pointers wrap correctly after slot 2.
- Reset mid-operation: count=2, drive iRST low between edges.
  - oValid_BM=0, oData_BM=0, oReady_AM=0 immediately, without waiting for a clock edge.
  - After release: oReady_AM=1, empty.
- With ELASTIC_REGISTER_FLUSH_EN, count=2, pulse iFlush with iValid_AM=1 (0xB).
  - No accept during the flush cycle.
  - oValid_BM=0 next cycle; a subsequent push of 0xB is output alone.
